// File: rtl/axi4_burst_master_if.sv
// AXI4 bus between the burst master and one memory-mapped slave.
// Covers the AW, W, B, AR and R channels.
interface axi4_burst_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        input RDATA, RRESP, RLAST, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        output RDATA, RRESP, RLAST, RVALID, input RREADY
    );
endinterface

// File: rtl/axi4_burst_master.sv
// AXI4 initiator: one INCR burst per command, seed+beat write pattern,
// streamed read beats, completion pulse with the worst response seen.
module axi4_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_seed,
    axi4_burst_master_if.master   axi,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  done_err
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [2:0] AX_SIZE = 3'($clog2(BYTES));
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_AW = 3'd1, S_W = 3'd2, S_B = 3'd3,
        S_AR = 3'd4, S_R = 3'd5, S_DONE = 3'd6
    } state_t;

    state_t                state_r, state_next_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [7:0]            len_r, beat_r;
    logic [DATA_WIDTH-1:0] wdata_r, rd_data_r;
    logic                  wlast_r;
    logic                  cmd_ready_r, awvalid_r, wvalid_r, bready_r, arvalid_r, rready_r;
    logic                  rd_valid_r, rd_last_r, done_r, done_err_r;
    logic [1:0]            done_resp_r;
    logic                  accept_s, reject_s, last_beat_s, w_hs_s, r_hs_s;
    logic [31:0]           burst_end_s;

    function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
        return (b > a) ? b : a;
    endfunction

    // A burst may not start misaligned nor run past the 4 KB page it starts in.
    assign burst_end_s = 32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) * 32'(BYTES));
    assign reject_s    = ((cmd_addr & ALIGN_MASK) != {ADDR_WIDTH{1'b0}}) || (burst_end_s > 32'd4096);
    assign accept_s    = cmd_valid && cmd_ready_r;
    assign last_beat_s = (beat_r == len_r);
    assign w_hs_s      = wvalid_r && axi.WREADY;
    assign r_hs_s      = rready_r && axi.RVALID;

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (reject_s)       state_next_s = S_DONE;
                    else if (cmd_write) state_next_s = S_AW;
                    else                state_next_s = S_AR;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_AW: begin
                if (awvalid_r && axi.AWREADY) state_next_s = S_W;
                else                          state_next_s = S_AW;
            end
            S_W: begin
                if (w_hs_s && wlast_r) state_next_s = S_B;
                else                   state_next_s = S_W;
            end
            S_B: begin
                if (bready_r && axi.BVALID) state_next_s = S_DONE;
                else                        state_next_s = S_B;
            end
            S_AR: begin
                if (arvalid_r && axi.ARREADY) state_next_s = S_R;
                else                          state_next_s = S_AR;
            end
            S_R: begin
                if (r_hs_s && (axi.RLAST || last_beat_s)) state_next_s = S_DONE;
                else                                      state_next_s = S_R;
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Registered handshake outputs and burst datapath.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            cmd_ready_r <= 1'b0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            done_r      <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_last_r   <= 1'b0;
            rd_data_r   <= {DATA_WIDTH{1'b0}};
            addr_r      <= {ADDR_WIDTH{1'b0}};
            len_r       <= 8'd0;
            beat_r      <= 8'd0;
            wdata_r     <= {DATA_WIDTH{1'b0}};
            wlast_r     <= 1'b0;
            done_resp_r <= 2'b00;
            done_err_r  <= 1'b0;
        end else begin
            cmd_ready_r <= (state_next_s == S_IDLE);
            awvalid_r   <= (state_next_s == S_AW);
            wvalid_r    <= (state_next_s == S_W);
            bready_r    <= (state_next_s == S_B);
            arvalid_r   <= (state_next_s == S_AR);
            rready_r    <= (state_next_s == S_R);
            done_r      <= (state_next_s == S_DONE);
            rd_valid_r  <= 1'b0;
            rd_last_r   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        addr_r      <= cmd_addr;
                        len_r       <= cmd_len;
                        beat_r      <= 8'd0;
                        wdata_r     <= cmd_seed;
                        wlast_r     <= (cmd_len == 8'd0);
                        done_err_r  <= reject_s;
                        done_resp_r <= reject_s ? 2'b10 : 2'b00;
                    end
                end
                S_W: begin
                    // Next beat's data/last are precomputed so they hold steady under stalls.
                    if (w_hs_s) begin
                        beat_r  <= beat_r + 8'd1;
                        wdata_r <= wdata_r + DATA_WIDTH'(1);
                        wlast_r <= ((beat_r + 8'd1) == len_r);
                    end
                end
                S_B: begin
                    if (bready_r && axi.BVALID) begin
                        done_resp_r <= axi.BRESP;
                    end
                end
                S_R: begin
                    if (r_hs_s) begin
                        rd_valid_r  <= 1'b1;
                        rd_data_r   <= axi.RDATA;
                        rd_last_r   <= last_beat_s;
                        done_resp_r <= worst_resp(done_resp_r, axi.RRESP);
                        beat_r      <= beat_r + 8'd1;
                        if (axi.RLAST != last_beat_s) begin
                            done_err_r <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign axi.AWADDR  = addr_r;
    assign axi.AWLEN   = len_r;
    assign axi.AWSIZE  = AX_SIZE;
    assign axi.AWBURST = 2'b01;
    assign axi.AWVALID = awvalid_r;
    assign axi.WDATA   = wdata_r;
    assign axi.WSTRB   = {BYTES{1'b1}};
    assign axi.WLAST   = wlast_r;
    assign axi.WVALID  = wvalid_r;
    assign axi.BREADY  = bready_r;
    assign axi.ARADDR  = addr_r;
    assign axi.ARLEN   = len_r;
    assign axi.ARSIZE  = AX_SIZE;
    assign axi.ARBURST = 2'b01;
    assign axi.ARVALID = arvalid_r;
    assign axi.RREADY  = rready_r;
    assign rd_data     = rd_data_r;
    assign rd_valid    = rd_valid_r;
    assign rd_last     = rd_last_r;
    assign done        = done_r;
    assign done_resp   = done_resp_r;
    assign done_err    = done_err_r;
endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: table of bursts against a small
// behavioural AXI slave, plus hand-written reset and stall sequences.
module tb_axi4_burst_master;
    logic        ACLK;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] cmd_seed;
    logic [31:0] rd_data;
    logic        rd_valid, rd_last, done, done_err;
    logic [1:0]  done_resp;

    axi4_burst_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) ifc ();

    axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
        .axi(ifc),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .done(done), .done_resp(done_resp), .done_err(done_err)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge ACLK) cyc <= cyc + 1;

    // Slave behaviour knobs
    int aw_stall       = 0;
    bit wtoggle        = 1'b0;
    int rresp_err_beat = -1;
    int rlast_beat     = -1;

    // Behavioural slave
    logic [31:0] mem [0:1023];
    int          aw_cnt;
    logic [9:0]  waddr_w, wbeat, raddr_w;
    int          rbeat;

    always @(posedge ACLK) begin
        if (!ARESETn) begin
            ifc.AWREADY <= 1'b0;
            ifc.WREADY  <= 1'b0;
            ifc.BVALID  <= 1'b0;
            ifc.BRESP   <= 2'b00;
            ifc.ARREADY <= 1'b0;
            ifc.RVALID  <= 1'b0;
            ifc.RDATA   <= 32'd0;
            ifc.RRESP   <= 2'b00;
            ifc.RLAST   <= 1'b0;
            aw_cnt      <= 0;
            waddr_w     <= 10'd0;
            wbeat       <= 10'd0;
            raddr_w     <= 10'd0;
            rbeat       <= 0;
        end else begin
            if (ifc.AWVALID && ifc.AWREADY) begin
                waddr_w     <= ifc.AWADDR[11:2];
                wbeat       <= 10'd0;
                ifc.AWREADY <= (aw_stall == 0);
                aw_cnt      <= 0;
            end else if (ifc.AWVALID) begin
                if (aw_cnt + 1 >= aw_stall) ifc.AWREADY <= 1'b1;
                aw_cnt <= aw_cnt + 1;
            end else begin
                ifc.AWREADY <= (aw_stall == 0);
                aw_cnt      <= 0;
            end
            ifc.WREADY <= wtoggle ? !ifc.WREADY : 1'b1;
            if (ifc.WVALID && ifc.WREADY) begin
                mem[waddr_w + wbeat] <= ifc.WDATA;
                wbeat <= wbeat + 10'd1;
            end
            if (ifc.BVALID && ifc.BREADY) ifc.BVALID <= 1'b0;
            else if (ifc.WVALID && ifc.WREADY && ifc.WLAST) ifc.BVALID <= 1'b1;
            ifc.ARREADY <= 1'b1;
            if (ifc.ARVALID && ifc.ARREADY) begin
                raddr_w    <= ifc.ARADDR[11:2];
                ifc.RVALID <= 1'b1;
                ifc.RDATA  <= mem[ifc.ARADDR[11:2]];
                ifc.RRESP  <= (rresp_err_beat == 0) ? 2'b10 : 2'b00;
                ifc.RLAST  <= (rlast_beat >= 0) ? (rlast_beat == 0) : (ifc.ARLEN == 8'd0);
                rbeat      <= 1;
            end else if (ifc.RVALID && ifc.RREADY) begin
                if (ifc.RLAST) begin
                    ifc.RVALID <= 1'b0;
                end else begin
                    ifc.RDATA <= mem[raddr_w + 10'(rbeat)];
                    ifc.RRESP <= (rresp_err_beat == rbeat) ? 2'b10 : 2'b00;
                    ifc.RLAST <= (rlast_beat >= 0) ? (rlast_beat == rbeat) : (rbeat == int'(ifc.ARLEN));
                    rbeat     <= rbeat + 1;
                end
            end
        end
    end

    // Monitor: beats, handshake order, stability under stall
    logic [31:0] beat_data[$];
    bit          beat_last[$];
    bit          aw_seen, ar_seen, aw_hs_seen;
    int          stab_err, order_err, done_pulses;
    logic [15:0] aw_addr_hs, ar_addr_hs;
    logic [7:0]  aw_len_hs, ar_len_hs;
    bit          w_stall_q, aw_stall_q;
    logic [31:0] wdata_q;
    logic        wlast_q;
    logic [15:0] awaddr_q;
    logic [7:0]  awlen_q;

    always @(negedge ACLK) begin
        if (ifc.WVALID && ifc.WREADY) begin
            beat_data.push_back(ifc.WDATA);
            beat_last.push_back(ifc.WLAST);
        end
        if (rd_valid) begin
            beat_data.push_back(rd_data);
            beat_last.push_back(rd_last);
        end
        if (ifc.AWVALID) aw_seen = 1'b1;
        if (ifc.ARVALID) ar_seen = 1'b1;
        if (ifc.AWVALID && ifc.AWREADY) begin
            aw_hs_seen = 1'b1;
            aw_addr_hs = ifc.AWADDR;
            aw_len_hs  = ifc.AWLEN;
        end
        if (ifc.ARVALID && ifc.ARREADY) begin
            ar_addr_hs = ifc.ARADDR;
            ar_len_hs  = ifc.ARLEN;
        end
        if (ifc.WVALID && !aw_hs_seen) order_err++;
        if (w_stall_q && (ifc.WDATA !== wdata_q || ifc.WLAST !== wlast_q)) stab_err++;
        if (aw_stall_q && (ifc.AWADDR !== awaddr_q || ifc.AWLEN !== awlen_q)) stab_err++;
        w_stall_q  = ifc.WVALID && !ifc.WREADY;
        aw_stall_q = ifc.AWVALID && !ifc.AWREADY;
        wdata_q    = ifc.WDATA;
        wlast_q    = ifc.WLAST;
        awaddr_q   = ifc.AWADDR;
        awlen_q    = ifc.AWLEN;
        if (done) done_pulses++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          write;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [31:0] seed;       // write seed, or expected first read word
        int          aw_stall;
        bit          wtoggle;
        int          rresp_err_beat;
        int          rlast_beat;
        int          exp_beats;
        int          exp_last;   // beat index carrying last, -1 for none
        bit          exp_err;
        logic [1:0]  exp_resp;
        int          exp_done;   // done cycle relative to accept, -1 unchecked
    } vec_t;

    vec_t vecs[10];

    task automatic clear_mon();
        beat_data.delete();
        beat_last.delete();
        aw_seen    = 1'b0;
        ar_seen    = 1'b0;
        aw_hs_seen = 1'b0;
        stab_err   = 0;
        order_err  = 0;
    endtask

    task automatic issue(input vec_t v, input string tag, output bit ok, output int acc_cyc);
        aw_stall       = v.aw_stall;
        wtoggle        = v.wtoggle;
        rresp_err_beat = v.rresp_err_beat;
        rlast_beat     = v.rlast_beat;
        clear_mon();
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        cmd_seed  = v.seed;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge ACLK); #1;
        end
        acc_cyc = cyc;
        if (ok) begin
            @(posedge ACLK); #1;
        end
        cmd_valid = 1'b0;
        check({tag, " cmd accepted"}, 64'(ok), 64'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit    ok;
        int    acc_cyc;
        bit    bus;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge ACLK); #1;
        issue(v, tag, ok, acc_cyc);
        if (!ok) return;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge ACLK); #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " done seen"}, 64'(ok), 64'd1);
        if (!ok) return;
        if (v.exp_done >= 0) check({tag, " done cycle"}, 64'(cyc - acc_cyc), 64'(v.exp_done));
        check({tag, " done_err"}, 64'(done_err), 64'(v.exp_err));
        check({tag, " done_resp"}, 64'(done_resp), 64'(v.exp_resp));
        check({tag, " cmd_ready in done"}, 64'(cmd_ready), 64'd0);
        @(negedge ACLK); #1;
        check({tag, " done one cycle"}, 64'(done), 64'd0);
        check({tag, " done_err held"}, 64'(done_err), 64'(v.exp_err));
        check({tag, " beat count"}, 64'(beat_data.size()), 64'(v.exp_beats));
        for (int i = 0; i < beat_data.size() && i < v.exp_beats; i++) begin
            check($sformatf("%s data[%0d]", tag, i), 64'(beat_data[i]), 64'(v.seed + 32'(i)));
            check($sformatf("%s last[%0d]", tag, i), 64'(beat_last[i]), 64'(i == v.exp_last));
        end
        bus = (v.exp_beats > 0);
        check({tag, " awvalid seen"}, 64'(aw_seen), 64'(v.write && bus));
        check({tag, " arvalid seen"}, 64'(ar_seen), 64'(!v.write && bus));
        if (v.write && bus) begin
            check({tag, " awaddr"}, 64'(aw_addr_hs), 64'(v.addr));
            check({tag, " awlen"}, 64'(aw_len_hs), 64'(v.len));
            check({tag, " stable under stall"}, 64'(stab_err), 64'd0);
            check({tag, " W after AW"}, 64'(order_err), 64'd0);
        end
        if (!v.write && bus) begin
            check({tag, " araddr"}, 64'(ar_addr_hs), 64'(v.addr));
            check({tag, " arlen"}, 64'(ar_len_hs), 64'(v.len));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        int   acc_cyc;
        int   pulses0;
        vec_t v;
        //        wr    addr      len   seed/base     stl tog rerr rlst beats last err resp  done
        vecs[0] = '{1'b1, 16'h0010, 8'd3, 32'h0000_00A0, 0, 1'b0, -1, -1, 4,  3, 1'b0, 2'b00, 7};
        vecs[1] = '{1'b0, 16'h0010, 8'd3, 32'h0000_00A0, 0, 1'b0, -1, -1, 4,  3, 1'b0, 2'b00, 6};
        vecs[2] = '{1'b1, 16'h0040, 8'd3, 32'h0000_1000, 5, 1'b1, -1, -1, 4,  3, 1'b0, 2'b00, -1};
        vecs[3] = '{1'b1, 16'h0FF8, 8'd3, 32'h0000_0011, 0, 1'b0, -1, -1, 0, -1, 1'b1, 2'b10, 1};
        vecs[4] = '{1'b0, 16'h0040, 8'd3, 32'h0000_1000, 0, 1'b0,  2, -1, 4,  3, 1'b0, 2'b10, 6};
        vecs[5] = '{1'b0, 16'h0010, 8'd3, 32'h0000_00A0, 0, 1'b0, -1,  1, 2, -1, 1'b1, 2'b00, 4};
        vecs[6] = '{1'b1, 16'h0FF0, 8'd3, 32'h0000_0055, 0, 1'b0, -1, -1, 4,  3, 1'b0, 2'b00, 7};
        vecs[7] = '{1'b0, 16'h0FF0, 8'd3, 32'h0000_0055, 0, 1'b0, -1, -1, 4,  3, 1'b0, 2'b00, 6};
        vecs[8] = '{1'b0, 16'h0012, 8'd0, 32'h0000_0000, 0, 1'b0, -1, -1, 0, -1, 1'b1, 2'b10, 1};
        vecs[9] = '{1'b1, 16'h0100, 8'd0, 32'hDEAD_BEEF, 0, 1'b0, -1, -1, 1,  0, 1'b0, 2'b00, 4};

        ARESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 16'h0000;
        cmd_len   = 8'd0;
        cmd_seed  = 32'd0;
        clear_mon();
        repeat (3) @(negedge ACLK);
        #1;
        check("reset cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset AWVALID", 64'(ifc.AWVALID), 64'd0);
        check("reset WVALID", 64'(ifc.WVALID), 64'd0);
        check("reset BREADY", 64'(ifc.BREADY), 64'd0);
        check("reset ARVALID", 64'(ifc.ARVALID), 64'd0);
        check("reset RREADY", 64'(ifc.RREADY), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset rd_valid", 64'(rd_valid), 64'd0);
        check("reset rd_last", 64'(rd_last), 64'd0);
        check("reset done_resp", 64'(done_resp), 64'd0);
        check("reset done_err", 64'(done_err), 64'd0);
        check("reset AWADDR", 64'(ifc.AWADDR), 64'd0);
        check("reset AWLEN", 64'(ifc.AWLEN), 64'd0);
        check("reset WDATA", 64'(ifc.WDATA), 64'd0);
        check("AWSIZE", 64'(ifc.AWSIZE), 64'd2);
        check("AWBURST", 64'(ifc.AWBURST), 64'd1);
        check("ARSIZE", 64'(ifc.ARSIZE), 64'd2);
        check("ARBURST", 64'(ifc.ARBURST), 64'd1);
        check("WSTRB", 64'(ifc.WSTRB), 64'hF);
        ARESETn = 1'b1;
        @(negedge ACLK); #1;
        check("cmd_ready after reset", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of a write burst
        @(negedge ACLK); #1;
        v = '{1'b1, 16'h0200, 8'd3, 32'h0000_0300, 0, 1'b0, -1, -1, 4, 3, 1'b0, 2'b00, -1};
        issue(v, "midrst", ok, acc_cyc);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (beat_data.size() >= 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge ACLK); #1;
        end
        check("midrst two beats", 64'(ok), 64'd1);
        pulses0 = done_pulses;
        @(posedge ACLK); #1;
        ARESETn = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK); #1;
        check("midrst WVALID", 64'(ifc.WVALID), 64'd0);
        check("midrst AWVALID", 64'(ifc.AWVALID), 64'd0);
        check("midrst BREADY", 64'(ifc.BREADY), 64'd0);
        check("midrst cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK); #1;
        check("midrst no done", 64'(done_pulses), 64'(pulses0));
        check("midrst cmd_ready after", 64'(cmd_ready), 64'd1);
        run_vec(10, '{1'b1, 16'h0300, 8'd1, 32'h0000_0077, 0, 1'b0, -1, -1, 2, 1, 1'b0, 2'b00, 5});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
